// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
package seg_pkg;

   // All segments dark (active-low bus).
   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Default number of multiplexed digits.
   localparam int DEF_DIGITS = 8;

   // Active-low codes produced by the 3-bit decoder stage, {a,b,c,d,e,f,g,dp}.
   localparam logic [7:0] SEG_D0 = 8'h03;
   localparam logic [7:0] SEG_D1 = 8'h9F;
   localparam logic [7:0] SEG_D2 = 8'h25;
   localparam logic [7:0] SEG_D3 = 8'h0D;
   localparam logic [7:0] SEG_D4 = 8'h99;
   localparam logic [7:0] SEG_D5 = 8'h49;
   localparam logic [7:0] SEG_D6 = 8'h41;
   localparam logic [7:0] SEG_D7 = 8'h1F;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit counters for the scan driver plus phase strobes decoded from them.
module seg_scan_timer #(
   parameter int DIGITS  = 8,
   parameter int CLK_DIV = 50000,
   parameter int BLANK   = 16,
   parameter int CW      = $clog2(CLK_DIV),
   parameter int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   output logic [DW-1:0] dig_idx_o,
   output logic          blank_o,
   output logic          show_o,
   output logic          frame_end_o
);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [DW-1:0] dig_idx_q, dig_idx_d;
   logic          in_blank;
   logic          slot_end;

   // Leading part of the slot is dark; a zero-length window never matches.
   generate
      if (BLANK == 0) begin : g_noblank
         assign in_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
         assign in_blank = (div_cnt_q < BLANK_C);
      end
   endgenerate

   assign slot_end = (div_cnt_q == DIV_LAST);

   // Advance slot counter, step digit on slot end; hold at zero while disabled.
   always_comb begin
      div_cnt_d = div_cnt_q;
      dig_idx_d = dig_idx_q;
      if (!en_i) begin
         div_cnt_d = '0;
         dig_idx_d = '0;
      end else if (slot_end) begin
         div_cnt_d = '0;
         dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         dig_idx_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         dig_idx_q <= dig_idx_d;
      end
   end

   assign dig_idx_o   = dig_idx_q;
   assign blank_o     = en_i & in_blank;
   assign show_o      = en_i & ~in_blank;
   assign frame_end_o = en_i & slot_end & (dig_idx_q == DIG_LAST);

endmodule

// File: rtl/seg_scan.sv
// Double-buffered, blanked time-multiplexed seven-segment scan driver.
module seg_scan
   import seg_pkg::*;
#(
   parameter int DIGITS  = DEF_DIGITS,
   parameter int CLK_DIV = 50000,
   parameter int BLANK   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_en,
   input  logic                i_load,
   input  logic [DIGITS*8-1:0] i_seg_bus,
   output logic [7:0]          o_seg,
   output logic [DIGITS-1:0]   o_an,
   output logic                o_frame
);

   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DIGITS-1:0][7:0] shadow_q, shadow_d;
   logic [DIGITS-1:0][7:0] disp_q, disp_d;
   logic [DIGITS-1:0][7:0] bus_w;
   logic                   pending_q, pending_d;
   logic [7:0]             seg_q, seg_d;
   logic [DIGITS-1:0]      an_q, an_d;
   logic                   frame_q;

   logic [DW-1:0] dig_idx;
   logic          t_blank, t_show, t_frame_end;
   logic          swap;

   assign bus_w = i_seg_bus;

   seg_scan_timer #(
      .DIGITS  (DIGITS),
      .CLK_DIV (CLK_DIV),
      .BLANK   (BLANK)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (i_en),
      .dig_idx_o   (dig_idx),
      .blank_o     (t_blank),
      .show_o      (t_show),
      .frame_end_o (t_frame_end)
   );

   // While disabled there is no frame to tear, so every cycle acts as a boundary.
   assign swap = t_frame_end | ~i_en;

   // Shadow capture and boundary swap; a load coinciding with the swap goes straight through.
   always_comb begin
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
      if (i_load) begin
         shadow_d  = bus_w;
         pending_d = 1'b1;
      end
      if (swap) begin
         if (i_load) begin
            disp_d    = bus_w;
            pending_d = 1'b0;
         end else if (pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
         end
      end
   end

   // Next output values from this cycle's phase; dark unless in the lit part of a slot.
   always_comb begin
      seg_d = SEG_OFF;
      an_d  = '1;
      if (t_show && !t_blank) begin
         seg_d = disp_q[dig_idx];
         an_d  = ~(DIGITS'(1) << dig_idx);
      end
   end

   // Buffers and registered outputs; reset darkens the display without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q  <= {DIGITS{SEG_OFF}};
         disp_q    <= {DIGITS{SEG_OFF}};
         pending_q <= 1'b0;
         seg_q     <= SEG_OFF;
         an_q      <= '1;
         frame_q   <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         frame_q   <= t_frame_end;
      end
   end

   assign o_seg   = seg_q;
   assign o_an    = an_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIGITS=4, CLK_DIV=8, BLANK=2 (frame = 32 cycles).
module tb_seg_scan;

   localparam int DIGITS = 4;
   localparam int N      = 160;

   logic                clk;
   logic                rst_n;
   logic                i_en;
   logic                i_load;
   logic [DIGITS*8-1:0] i_seg_bus;
   logic [7:0]          o_seg;
   logic [DIGITS-1:0]   o_an;
   logic                o_frame;

   seg_scan #(.DIGITS(DIGITS), .CLK_DIV(8), .BLANK(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (i_en),
      .i_load    (i_load),
      .i_seg_bus (i_seg_bus),
      .o_seg     (o_seg),
      .o_an      (o_an),
      .o_frame   (o_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [7:0] seg;
      logic       frame;
   } vec_t;

   vec_t vecs[$];

   logic [3:0] obs_an  [0:N-1];
   logic [7:0] obs_seg [0:N-1];
   logic       obs_fr  [0:N-1];

   // Output observed #1 after edge k+1 reflects source cycle k.
   task automatic step(input int c);
      @(posedge clk);
      #1;
      if (c >= 0 && c < N) begin
         obs_an[c]  = o_an;
         obs_seg[c] = o_seg;
         obs_fr[c]  = o_frame;
      end
   endtask

   initial begin
      logic [3:0] exp_an;
      rst_n     = 1'b0;
      i_en      = 1'b1;
      i_load    = 1'b0;
      i_seg_bus = '1;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_seg", 32'(o_seg), 32'h0000_00FF);
      check("rst_an", 32'(o_an), 32'h0000_000F);
      check("rst_frame", 32'(o_frame), 32'h0);
      rst_n = 1'b1;

      // Main scripted run: inputs for source cycle c are applied before its edge.
      for (int c = 0; c < N; c++) begin
         i_load    = 1'b0;
         i_en      = 1'b1;
         if (c == 3)  begin i_load = 1'b1; i_seg_bus = 32'h1F0D9F03; end
         if (c == 42) begin i_load = 1'b1; i_seg_bus = {4{8'h25}}; end
         if (c == 95) begin i_load = 1'b1; i_seg_bus = {4{8'h61}}; end
         if (c >= 115 && c <= 119) i_en = 1'b0;
         if (c == 116) begin i_load = 1'b1; i_seg_bus = {4{8'h99}}; end
         step(c);
      end
      i_load = 1'b0;
      i_en   = 1'b1;

      // Scan order over frame 0: two dark cycles then six lit per slot.
      for (int c = 0; c < 32; c++) begin
         exp_an = ((c % 8) < 2) ? 4'b1111 : ~(4'b0001 << (c / 8));
         check($sformatf("scan_an[%0d]", c), 32'(obs_an[c]), 32'(exp_an));
         check($sformatf("scan_fr[%0d]", c), 32'(obs_fr[c]), (c == 31) ? 32'h1 : 32'h0);
      end

      vecs.push_back('{0,   4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{2,   4'b1110, 8'hFF, 1'b0});
      vecs.push_back('{26,  4'b0111, 8'hFF, 1'b0});
      vecs.push_back('{31,  4'b0111, 8'hFF, 1'b1});
      vecs.push_back('{32,  4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{34,  4'b1110, 8'h03, 1'b0});
      vecs.push_back('{42,  4'b1101, 8'h9F, 1'b0});
      vecs.push_back('{50,  4'b1011, 8'h0D, 1'b0});
      vecs.push_back('{63,  4'b0111, 8'h1F, 1'b1});
      vecs.push_back('{66,  4'b1110, 8'h25, 1'b0});
      vecs.push_back('{90,  4'b0111, 8'h25, 1'b0});
      vecs.push_back('{95,  4'b0111, 8'h25, 1'b1});
      vecs.push_back('{98,  4'b1110, 8'h61, 1'b0});
      vecs.push_back('{114, 4'b1011, 8'h61, 1'b0});
      vecs.push_back('{115, 4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{119, 4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{120, 4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{121, 4'b1111, 8'hFF, 1'b0});
      vecs.push_back('{122, 4'b1110, 8'h99, 1'b0});
      vecs.push_back('{130, 4'b1101, 8'h99, 1'b0});
      vecs.push_back('{150, 4'b0111, 8'h99, 1'b0});
      vecs.push_back('{151, 4'b0111, 8'h99, 1'b1});

      foreach (vecs[i]) begin
         check($sformatf("an@%0d", vecs[i].cyc), 32'(obs_an[vecs[i].cyc]), 32'(vecs[i].an));
         check($sformatf("seg@%0d", vecs[i].cyc), 32'(obs_seg[vecs[i].cyc]), 32'(vecs[i].seg));
         check($sformatf("frame@%0d", vecs[i].cyc), 32'(obs_fr[vecs[i].cyc]), 32'(vecs[i].frame));
      end

      // Continue into digit 1 SHOW of the next frame, then reset without a clock edge.
      for (int c = 160; c < 163; c++) step(-1);
      check("pre_rst_an", 32'(o_an), 32'h0000_000D);
      check("pre_rst_seg", 32'(o_seg), 32'h0000_0099);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(o_seg), 32'h0000_00FF);
      check("async_rst_an", 32'(o_an), 32'h0000_000F);
      check("async_rst_frame", 32'(o_frame), 32'h0);

      // After release the display buffer must be dark again.
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) step(-1);
      check("post_rst_an", 32'(o_an), 32'h0000_000E);
      check("post_rst_seg", 32'(o_seg), 32'h0000_00FF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Time-multiplexed scan driver that sits directly downstream of the 3-bit-to-seven-segment decoder stage.
- Takes DIGITS active-low 8-bit segment patterns, one per decoder instance, and drives a shared segment bus plus per-digit active-low enables.
- Double-buffers patterns so updates never tear mid-frame.
- Inserts a blanking window at every digit switch to suppress ghosting.

Parameters:
- DIGITS, 8: number of multiplexed digits (>=1).
- CLK_DIV, 50000: clock cycles per digit slot (>BLANK, >=2).
- BLANK, 16: leading cycles of each slot with all digits off (0 disables blanking).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- i_en  in  1  scan enable.
- i_load  in  1  single-cycle strobe that captures i_seg_bus.
- i_seg_bus  in  DIGITS*8  active-low patterns; digit k occupies [8k+7:8k].
- o_seg  out  8  shared segment bus, active-low.
- o_an  out  DIGITS  digit enables, active-low, at most one low.
- o_frame  out  1  one-cycle pulse, last cycle of each frame.

Behaviour:
- Design uses one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - shadow_buf, disp_buf all 8'hFF; pending=0; div_cnt=0; dig_idx=0.
  - o_seg=8'hFF, o_an=all ones, o_frame=0.
  - Reset assertion mid-scan blanks the outputs immediately, with no clock edge required.
- Counters:
  - div_cnt runs 0..CLK_DIV-1.
  - dig_idx increments when div_cnt==CLK_DIV-1 and wraps DIGITS-1 -> 0.
  - Frame = DIGITS*CLK_DIV cycles.
- Phases, decoded from the counters:
  - BLANK: div_cnt<BLANK.
  - SHOW: div_cnt>=BLANK.
  - OFF: i_en=0.
- Outputs are registered and reflect the counter/phase values of the previous cycle. Latency is exactly one clock.
  - SHOW: o_an = ~(1<<dig_idx); o_seg = disp_buf[dig_idx].
  - BLANK or OFF: o_an = all ones; o_seg = 8'hFF.
- o_frame is registered the same way. It is high for one cycle whose source cycle has dig_idx==DIGITS-1 and div_cnt==CLK_DIV-1 with i_en=1.
- Buffering:
  - i_load=1: shadow_buf <= i_seg_bus; pending <= 1.
  - At the frame boundary (source cycle of o_frame): if pending, disp_buf <= shadow_buf and pending <= 0.
  - Simultaneous i_load at the boundary: disp_buf <= i_seg_bus directly; shadow_buf also loaded; pending ends 0.
  - i_load mid-frame never changes the displayed digits before the next boundary.
  - Back-to-back i_load: last capture wins.
- Disable (i_en=0):
  - div_cnt and dig_idx are held at 0.
  - Outputs blank on the next edge; o_frame=0.
  - i_load is still accepted, and pending data transfers to disp_buf on the next cycle while disabled.
- Re-enable: scan restarts at digit 0, BLANK phase.
- Widths:
  - div_cnt is $clog2(CLK_DIV) bits.
  - dig_idx is max(1,$clog2(DIGITS)) bits.
  - No out-of-range index is ever produced.

Decomposition:
- Shared package seg_pkg:
  - SEG_OFF=8'hFF.
  - The eight active-low digit codes used by the decoder stage.
  - Default DIGITS.
- One natural sub-module: seg_scan_timer. It owns div_cnt/dig_idx and produces the blank, show and frame_end strobes.
- seg_scan keeps the buffers and output registers.

Test Plan (DIGITS=4, CLK_DIV=8, BLANK=2):
- Reset: rst_n=0 asserted mid-SHOW with no clk edge -> o_seg=8'hFF, o_an=4'b1111, o_frame=0 immediately.
- Scan order: i_en=1 from reset release -> o_an sequence per 8-cycle slot is 1111,1111 then 6x 1110, then the same pattern for 1101, 1011, 0111. o_frame pulses every 32 cycles, coinciding with the last 0111 cycle.
- Initial buffer: i_load of bus {D3=8'h1F,D2=8'h0D,D1=8'h9F,D0=8'h03} in frame 0 -> frame 0 shows only 8'hFF. Frame 1 shows D0 with o_seg=8'h03 while o_an=1110, and D1 with 8'h9F while o_an=1101.
- Tear-free: i_load of all-8'h25 during digit 1 of frame 1 -> digits 2,3 of frame 1 still show old values. All digits show 8'h25 from frame 2.
- Boundary collision: i_load of all-8'h61 in exactly the frame_end source cycle -> the next frame's digit 0 shows 8'h61.
- Enable gating: i_en=0 for 5 cycles during digit 2 SHOW -> o_an=1111, o_seg=8'hFF one cycle later. After re-enable, 2 blank cycles, then o_an=1110.
